turfio_bus_master: RTL and testbench

- Initiator side of the TURF byte-wide register bus (nCSTURF / TURF_WnR / TURF_DIO). It runs on the TURFIO in the 33 MHz domain.
- It turns single 32-bit register read/write requests from local TURFIO logic into framed byte transactions, using an address byte followed by four data bytes.
- The TURF register interface is the responder on the other end.
- The tristate is split into dio_o/dio_oe_o/dio_i; the IOBUF sits at the TURFIO top level.

---
 rtl/turfio_bus_master_if.sv | 26 ++
 rtl/turfio_bus_master.sv | 161 ++++++++++++++++
 tb/tb_turfio_bus_master.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turfio_bus_master_if.sv
// Request-side and TURF-bus-side signals of the TURFIO register bus initiator.
// The master modport is the initiator; the slave modport is the local requester plus the bus responder.
interface turfio_bus_master_if;
    logic        req_i;
    logic        wr_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        nCSTURF_o;
    logic        TURF_WnR_o;
    logic [7:0]  dio_o;
    logic        dio_oe_o;
    logic [7:0]  dio_i;

    modport master (
        input  req_i, wr_i, addr_i, wdata_i, dio_i,
        output busy_o, ack_o, rdata_o, nCSTURF_o, TURF_WnR_o, dio_o, dio_oe_o
    );

    modport slave (
        output req_i, wr_i, addr_i, wdata_i, dio_i,
        input  busy_o, ack_o, rdata_o, nCSTURF_o, TURF_WnR_o, dio_o, dio_oe_o
    );
endinterface

// File: rtl/turfio_bus_master.sv
// TURF byte-wide register bus initiator: one 32-bit read or write per request,
// framed as an address byte followed by four data bytes, LSB first.
module turfio_bus_master #(
    parameter int unsigned TURNAROUND = 1,
    parameter int unsigned GAP        = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    turfio_bus_master_if.master bus
);

    localparam logic [1:0] TURN_LAST = 2'(TURNAROUND - 1);
    localparam logic [1:0] GAP_LAST  = 2'(GAP - 1);
    localparam logic [1:0] BYTE_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_TURN  = 3'd3,
        ST_RDATA = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    logic [1:0]  rst_sync_q;
    logic        rst_n_s;
    state_t      state_q;
    logic        wr_q;
    logic [31:0] shift_q;
    logic [1:0]  byte_cnt_q;
    logic [1:0]  wait_cnt_q;
    logic        busy_q;
    logic        ack_q;
    logic        ncs_q;
    logic        wnr_q;
    logic        oe_q;
    logic [7:0]  dio_q;
    logic [31:0] rdata_q;

    // Reset asserts asynchronously and releases two clock edges after rst_n_i rises
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    // Transaction sequencer; each bus output is set on the edge that enters the cycle it belongs to
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            shift_q    <= 32'h0000_0000;
            byte_cnt_q <= 2'd0;
            wait_cnt_q <= 2'd0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            ncs_q      <= 1'b1;
            wnr_q      <= 1'b0;
            oe_q       <= 1'b0;
            dio_q      <= 8'h00;
            rdata_q    <= 32'h0000_0000;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        state_q <= ST_ADDR;
                        wr_q    <= bus.wr_i;
                        shift_q <= bus.wdata_i;
                        busy_q  <= 1'b1;
                        ncs_q   <= 1'b0;
                        wnr_q   <= bus.wr_i;
                        oe_q    <= 1'b1;
                        dio_q   <= bus.addr_i;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    byte_cnt_q <= 2'd0;
                    wait_cnt_q <= 2'd0;
                    if (wr_q) begin
                        state_q <= ST_WDATA;
                        dio_q   <= shift_q[7:0];
                        shift_q <= {8'h00, shift_q[31:8]};
                    end else begin
                        // Release the bus before the responder can start driving
                        state_q <= ST_TURN;
                        wnr_q   <= 1'b0;
                        oe_q    <= 1'b0;
                        dio_q   <= 8'h00;
                    end
                end
                ST_WDATA: begin
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_q    <= ST_GAP;
                        ncs_q      <= 1'b1;
                        wnr_q      <= 1'b0;
                        oe_q       <= 1'b0;
                        dio_q      <= 8'h00;
                        ack_q      <= 1'b1;
                        wait_cnt_q <= 2'd0;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        dio_q      <= shift_q[7:0];
                        shift_q    <= {8'h00, shift_q[31:8]};
                    end
                end
                ST_TURN: begin
                    if (wait_cnt_q == TURN_LAST) begin
                        state_q    <= ST_RDATA;
                        byte_cnt_q <= 2'd0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                ST_RDATA: begin
                    shift_q <= {bus.dio_i, shift_q[31:8]};
                    if (byte_cnt_q == BYTE_LAST) begin
                        state_q    <= ST_GAP;
                        ncs_q      <= 1'b1;
                        ack_q      <= 1'b1;
                        rdata_q    <= {bus.dio_i, shift_q[31:8]};
                        wait_cnt_q <= 2'd0;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                ST_GAP: begin
                    if (wait_cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ncs_q   <= 1'b1;
                    wnr_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    dio_q   <= 8'h00;
                end
            endcase
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.ack_o      = ack_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.nCSTURF_o  = ncs_q;
    assign bus.TURF_WnR_o = wnr_q;
    assign bus.dio_o      = dio_q;
    assign bus.dio_oe_o   = oe_q;

endmodule

// File: tb/tb_turfio_bus_master.sv
// Bench for turfio_bus_master: two instances (TURNAROUND/GAP = 1/1 and 3/2) share the request
// inputs and are each compared every cycle against a transaction-offset model.
module tb_turfio_bus_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic [31:0] next_rd = 32'h0;
    logic [7:0]  dio_in [2];
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    turfio_bus_master_if bus0 ();
    turfio_bus_master_if bus1 ();

    assign bus0.req_i = req;   assign bus1.req_i = req;
    assign bus0.wr_i = wr;     assign bus1.wr_i = wr;
    assign bus0.addr_i = addr; assign bus1.addr_i = addr;
    assign bus0.wdata_i = wdata; assign bus1.wdata_i = wdata;
    assign bus0.dio_i = dio_in[0];
    assign bus1.dio_i = dio_in[1];

    turfio_bus_master #(.TURNAROUND(1), .GAP(1)) u_dut0 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus0));
    turfio_bus_master #(.TURNAROUND(3), .GAP(2)) u_dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus1));

    always #15 clk = ~clk;

    function automatic int ta(input int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int ga(input int i); return (i == 0) ? 1 : 2; endfunction

    // Model: per instance, whether a transaction is active and which cycle of it we are in (1 = address byte)
    bit        act_m [2];
    int        k_m [2];
    bit        twr_m [2];
    bit [7:0]  taddr_m [2];
    bit [31:0] twd_m [2];
    bit [31:0] trd_m [2];
    bit [31:0] erd_m [2];
    int        sync_m [2];

    function automatic int nlow_of(input int i);
        return twr_m[i] ? 5 : 5 + ta(i);
    endfunction

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h expected=%h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Advance the model on each clock edge; reset takes effect immediately
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act_m[i] = 1'b0; sync_m[i] = 0; erd_m[i] = 32'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act_m[i]) begin
                    if (k_m[i] == nlow_of(i) + ga(i)) begin
                        act_m[i] = 1'b0;
                    end else begin
                        k_m[i]++;
                        if (!twr_m[i] && k_m[i] == nlow_of(i) + 1) erd_m[i] = trd_m[i];
                    end
                end else if (sync_m[i] >= 2 && req) begin
                    act_m[i] = 1'b1; k_m[i] = 1; twr_m[i] = wr;
                    taddr_m[i] = addr; twd_m[i] = wdata; trd_m[i] = next_rd;
                end
                if (sync_m[i] < 2) sync_m[i]++;
            end
        end
    end

    int lowrun [2];
    int gaprun [2];
    bit prevncs [2] = '{1'b1, 1'b1};
    bit hadtx [2];

    task automatic cmp_inst(input int i, input logic ncs, input logic wnr, input logic oe,
                            input logic [7:0] dio, input logic busy, input logic ack, input logic [31:0] rdata);
        bit       a;
        int       k;
        int       nl;
        bit       e_ncs, e_oe, e_wnr, e_ack;
        bit [7:0] e_dio;
        a = act_m[i]; k = k_m[i]; nl = nlow_of(i);
        e_ncs = !(a && k <= nl);
        e_oe  = a && (k == 1 || (twr_m[i] && k <= 5));
        e_wnr = a && twr_m[i] && k <= nl;
        e_ack = a && k == nl + 1;
        e_dio = 8'h00;
        if (a && k == 1) e_dio = taddr_m[i];
        else if (a && twr_m[i] && k >= 2 && k <= 5) e_dio = 8'(twd_m[i] >> (8 * (k - 2)));
        chk("ncs", i, ncs, e_ncs);
        chk("oe", i, oe, e_oe);
        chk("wnr", i, wnr, e_wnr);
        chk("dio", i, dio, e_dio);
        chk("busy", i, busy, a);
        chk("ack", i, ack, e_ack);
        chk("rdata", i, rdata, erd_m[i]);
        if (!rst_n) begin
            lowrun[i] = 0; gaprun[i] = 0; prevncs[i] = 1'b1; hadtx[i] = 1'b0;
        end else if (ncs == 1'b0) begin
            if (prevncs[i] && hadtx[i]) chk("gap_len", i, gaprun[i], ga(i));
            gaprun[i] = 0; lowrun[i]++; prevncs[i] = 1'b0;
        end else begin
            if (!prevncs[i]) begin
                chk("ncs_low_len", i, lowrun[i], nl);
                hadtx[i] = 1'b1; lowrun[i] = 0;
            end
            if (busy) gaprun[i]++;
            prevncs[i] = 1'b1;
        end
        // Responder drives only in the four read-data cycles; random junk elsewhere
        if (rst_n && a && !twr_m[i] && k >= ta(i) + 2 && k <= ta(i) + 5) begin
            dio_in[i] = 8'(trd_m[i] >> (8 * (k - ta(i) - 2)));
            chk("contention", i, oe, 1'b0);
        end else begin
            dio_in[i] = 8'($urandom);
        end
    endtask

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_inst(0, bus0.nCSTURF_o, bus0.TURF_WnR_o, bus0.dio_oe_o, bus0.dio_o, bus0.busy_o, bus0.ack_o, bus0.rdata_o);
            cmp_inst(1, bus1.nCSTURF_o, bus1.TURF_WnR_o, bus1.dio_oe_o, bus1.dio_o, bus1.busy_o, bus1.ack_o, bus1.rdata_o);
        end
    end

    task automatic wait_idle();
        for (int n = 0; n < 40 && (bus0.busy_o || bus1.busy_o); n++) @(negedge clk);
        chk("idle_timeout", 0, bus0.busy_o | bus1.busy_o, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk); #5 rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int         nl0, nl1, oe0, hb1, ackc, ackat;
        logic [39:0] seq;
        logic [31:0] rd_at_ack;
        logic [7:0]  addr_seen;
        bit          got;
        dio_in[0] = 8'h00; dio_in[1] = 8'h00;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ncs", 0, bus0.nCSTURF_o, 1'b1);
        chk("rst_oe", 0, bus0.dio_oe_o, 1'b0);
        chk("rst_busy", 1, bus1.busy_o, 1'b0);
        chk("rst_rdata", 0, bus0.rdata_o, 32'h0);
        release_reset();

        // Directed write: 05, EF, BE, AD, DE
        @(negedge clk); req = 1'b1; wr = 1'b1; addr = 8'h05; wdata = 32'hDEAD_BEEF;
        @(negedge clk); req = 1'b0;
        nl0 = 0; seq = 40'h0; ackc = 0; ackat = 0;
        for (int c = 1; c <= 10; c++) begin
            if (!bus0.nCSTURF_o) begin
                nl0++;
                chk("wr_wnr", 0, bus0.TURF_WnR_o, 1'b1);
                chk("wr_oe", 0, bus0.dio_oe_o, 1'b1);
                seq = {seq[31:0], bus0.dio_o};
            end
            if (bus0.ack_o) begin ackc++; ackat = c; end
            if (c == 6) chk("wr_busy_gap", 0, bus0.busy_o, 1'b1);
            if (c == 7) chk("wr_busy_clear", 0, bus0.busy_o, 1'b0);
            @(negedge clk);
        end
        chk("wr_ncs_low", 0, nl0, 5);
        chk("wr_bytes", 0, seq, 40'h05_EF_BE_AD_DE);
        chk("wr_ack_count", 0, ackc, 1);
        chk("wr_ack_cycle", 0, ackat, 6);

        // Directed read: responder returns 78,56,34,12
        wait_idle();
        @(negedge clk); req = 1'b1; wr = 1'b0; addr = 8'h0A; next_rd = 32'h1234_5678;
        @(negedge clk); req = 1'b0;
        nl0 = 0; nl1 = 0; oe0 = 0; hb1 = 0; ackat = 0; rd_at_ack = 32'h0; addr_seen = 8'h00;
        for (int c = 1; c <= 14; c++) begin
            if (!bus0.nCSTURF_o) nl0++;
            if (bus0.dio_oe_o) begin oe0++; addr_seen = bus0.dio_o; end
            if (bus0.ack_o) begin ackat = c; rd_at_ack = bus0.rdata_o; end
            if (!bus1.nCSTURF_o) nl1++;
            if (bus1.nCSTURF_o && bus1.busy_o) hb1++;
            @(negedge clk);
        end
        chk("rd_ncs_low", 0, nl0, 6);
        chk("rd_oe_cycles", 0, oe0, 1);
        chk("rd_addr", 0, addr_seen, 8'h0A);
        chk("rd_ack_cycle", 0, ackat, 7);
        chk("rd_data", 0, rd_at_ack, 32'h1234_5678);
        chk("rd_hold", 0, bus0.rdata_o, 32'h1234_5678);
        chk("rd_ncs_low_t3", 1, nl1, 8);
        chk("rd_gap_high_g2", 1, hb1, 2);
        chk("rd_data_t3", 1, bus1.rdata_o, 32'h1234_5678);

        // Busy rejection: pulse req during WDATA
        wait_idle();
        @(negedge clk); req = 1'b1; wr = 1'b1; addr = 8'h33; wdata = $urandom;
        @(negedge clk); req = 1'b0;
        ackc = 0;
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) req = 1'b1;
            else req = 1'b0;
            if (bus0.ack_o) ackc++;
            @(negedge clk);
        end
        chk("busy_reject_acks", 0, ackc, 1);
        wait_idle();
        @(negedge clk); req = 1'b1; wr = 1'b0; addr = 8'h44; next_rd = $urandom;
        @(negedge clk); req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus0.ack_o) got = 1'b1;
            else @(negedge clk);
        end
        chk("after_busy_accept", 0, got, 1'b1);

        // Back-to-back with alternating direction
        wait_idle();
        @(negedge clk); req = 1'b1; wr = 1'b1; addr = 8'($urandom); wdata = $urandom; next_rd = $urandom;
        ackc = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus0.ack_o) begin
                ackc++; wr = ~wr; addr = 8'($urandom); wdata = $urandom; next_rd = $urandom;
            end
        end
        req = 1'b0;
        chk("b2b_acks", 0, ackc, 8);

        // Reset in the second read-data cycle of instance 0
        wait_idle();
        @(negedge clk); req = 1'b1; wr = 1'b0; addr = 8'h5A; next_rd = $urandom;
        @(negedge clk); req = 1'b0;
        repeat (3) @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        chk("mid_rst_ncs", 0, bus0.nCSTURF_o, 1'b1);
        chk("mid_rst_oe", 0, bus0.dio_oe_o, 1'b0);
        chk("mid_rst_busy", 0, bus0.busy_o, 1'b0);
        chk("mid_rst_rdata", 0, bus0.rdata_o, 32'h0);
        ackc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus0.ack_o) ackc++;
        end
        chk("mid_rst_no_ack", 0, ackc, 0);
        release_reset();
        @(negedge clk); req = 1'b1; wr = 1'b0; addr = 8'h66; next_rd = 32'hCAFE_F00D;
        @(negedge clk); req = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (bus0.ack_o) got = 1'b1;
            else @(negedge clk);
        end
        chk("post_rst_ack", 0, got, 1'b1);
        chk("post_rst_rdata", 0, bus0.rdata_o, 32'hCAFE_F00D);

        // Random traffic
        wait_idle();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            req = 1'($urandom_range(0, 1)); wr = 1'($urandom_range(0, 1));
            addr = 8'($urandom); wdata = $urandom; next_rd = $urandom;
        end
        req = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
